// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x-oversampled UART receiver.
// Synchronises rx, finds the start bit, samples each bit at mid-bit, assembles
// the word LSB-first, checks the stop bit and hands the word to the host over
// a valid/ack handshake with framing and overrun error pulses.
// Optional parity bit support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_error,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   fe_q, fe_d;
    logic                   ov_q, ov_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   pe_q, pe_d;
`endif
    logic                   rx_s;
    logic                   word_good;

    // All line decisions are taken on the second synchroniser stage only.
    assign rx_s = sync_q[1];

    // Next-state logic: the FSM only moves on baud ticks; rx_ack is honoured every clock.
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], rx};
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ack;
        fe_d       = 1'b0;
        ov_d       = 1'b0;
        word_good  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        pe_d       = 1'b0;
`endif
        if (baud_tick) begin
            cnt_d = cnt_q + CW'(1);
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) state_d = START;
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        // A line that is high again at mid start bit was a glitch.
                        if (!rx_s) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        par_bad_d = rx_s ^ (^shift_q) ^ parity_odd;
                        state_d   = STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        // Leave at mid stop bit so the next start edge is never missed.
                        cnt_d     = '0;
                        state_d   = IDLE;
                        rx_data_d = shift_q;
                        fe_d      = ~rx_s;
                        ov_d      = rx_valid_q & ~rx_ack;
`ifdef UART_RX_PARITY_EN
                        pe_d      = par_bad_q;
                        word_good = rx_s & ~par_bad_q;
`else
                        word_good = rx_s;
`endif
                        if (word_good) rx_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers; the asynchronous reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sync_q     <= 2'b11;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            pe_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            pe_q       <= pe_d;
`endif
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = fe_q;
    assign overrun_error = ov_q;
    assign busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error  = pe_q;
`endif

endmodule
